cache_plru8: RTL and testbench



---
 rtl/cache_pkg.sv | 36 +++
 rtl/plru_tree_logic.sv | 18 +
 rtl/cache_plru8.sv | 93 +++++++++
 tb/tb_cache_plru8.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared PLRU constants, tree type and walk/touch/invalid-first helpers
package cache_pkg;

   localparam int WAYS      = 8;
   localparam int PLRU_BITS = 7;

   typedef logic [PLRU_BITS-1:0] plru_tree_t;

   // Bit 0 is the root; a 0 in any node steers the victim toward the lower half.
   function automatic logic [2:0] plru_walk(input plru_tree_t tree);
      logic [2:0] v;
      v[2] = tree[0];
      v[1] = tree[1 + int'(v[2])];
      v[0] = tree[3 + int'(v[2:1])];
      return v;
   endfunction

   function automatic plru_tree_t plru_touch(input plru_tree_t tree, input logic [2:0] way);
      plru_tree_t t;
      t = tree;
      t[0]                      = ~way[2];
      t[1 + int'(way[2])]       = ~way[1];
      t[3 + int'(way[2:1])]     = ~way[0];
      return t;
   endfunction

   function automatic logic [2:0] first_invalid(input logic [WAYS-1:0] valid);
      logic [2:0] w;
      w = 3'd0;
      for (int i = WAYS - 1; i >= 0; i--) begin
         if (!valid[i]) w = 3'(i);
      end
      return w;
   endfunction

endpackage

// File: rtl/plru_tree_logic.sv
// rtl/plru_tree_logic.sv - optional touch of one 7-bit PLRU tree followed by the victim walk
import cache_pkg::*;

module plru_tree_logic (
   input  plru_tree_t  cur_tree,
   input  logic        touch_en,
   input  logic [2:0]  touch_way,
   output plru_tree_t  next_tree,
   output logic [2:0]  victim
);

   always_comb begin
      next_tree = cur_tree;
      if (touch_en) next_tree = plru_touch(cur_tree, touch_way);
      victim = plru_walk(next_tree);
   end

endmodule

// File: rtl/cache_plru8.sv
// rtl/cache_plru8.sv - 8-way tree PLRU unit with flush sweep; PLRU_INVALID_FIRST_EN picks invalid ways first
import cache_pkg::*;

module cache_plru8 #(
   parameter int SETS    = 64,
   parameter int INDEX_W = 6
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               flush_req,
   output logic               ready,
   input  logic               lookup_valid,
   input  logic [INDEX_W-1:0] lookup_index,
   input  logic [WAYS-1:0]    way_valid,
   output logic               victim_valid,
   output logic [2:0]         victim_way,
   input  logic               access_valid,
   input  logic [INDEX_W-1:0] access_index,
   input  logic [2:0]         access_way
);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_FLUSH = 1'b1;

   logic [0:0]         state;
   logic [INDEX_W-1:0] flush_cnt;
   plru_tree_t         trees [SETS];

   logic       acc_fire;
   logic       lkp_fire;
   logic       fwd;
   plru_tree_t acc_tree;
   plru_tree_t unused_lkp_tree;
   logic [2:0] unused_acc_victim;
   logic [2:0] walk_way;
   logic [2:0] sel_way;

   assign ready    = (state == ST_IDLE);
   // A flush request wins over a same-cycle access, which is dropped.
   assign acc_fire = access_valid && ready && !flush_req;
   assign lkp_fire = lookup_valid && ready;
   assign fwd      = acc_fire && (access_index == lookup_index);

   plru_tree_logic u_access (
      .cur_tree  (trees[access_index]),
      .touch_en  (acc_fire),
      .touch_way (access_way),
      .next_tree (acc_tree),
      .victim    (unused_acc_victim)
   );

   // Applying the same touch on the lookup side forwards a same-index access.
   plru_tree_logic u_lookup (
      .cur_tree  (trees[lookup_index]),
      .touch_en  (fwd),
      .touch_way (access_way),
      .next_tree (unused_lkp_tree),
      .victim    (walk_way)
   );

`ifdef PLRU_INVALID_FIRST_EN
   assign sel_way = (way_valid != 8'hFF) ? first_invalid(way_valid) : walk_way;
`else
   logic unused_way_valid;
   assign unused_way_valid = ^way_valid;
   assign sel_way          = walk_way;
`endif

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state        <= ST_IDLE;
         flush_cnt    <= '0;
         victim_valid <= 1'b0;
         victim_way   <= 3'd0;
         for (int s = 0; s < SETS; s++) trees[s] <= '0;
      end else begin
         victim_valid <= lkp_fire;
         if (lkp_fire) victim_way <= sel_way;

         if (state == ST_FLUSH) begin
            trees[flush_cnt] <= '0;
            flush_cnt        <= flush_cnt + INDEX_W'(1);
            if (flush_cnt == INDEX_W'(SETS - 1)) state <= ST_IDLE;
         end else if (flush_req) begin
            state     <= ST_FLUSH;
            flush_cnt <= '0;
         end else if (acc_fire) begin
            trees[access_index] <= acc_tree;
         end
      end
   end

endmodule

// File: tb/tb_cache_plru8.sv
// tb/tb_cache_plru8.sv - directed self-checking bench for cache_plru8
module tb_cache_plru8;

   logic       clk = 1'b0;
   logic       resetn;
   logic       flush_req;
   logic       ready;
   logic       lookup_valid;
   logic [5:0] lookup_index;
   logic [7:0] way_valid;
   logic       victim_valid;
   logic [2:0] victim_way;
   logic       access_valid;
   logic [5:0] access_index;
   logic [2:0] access_way;

   int errors = 0;
   int checks = 0;

   cache_plru8 #(.SETS(64), .INDEX_W(6)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .flush_req    (flush_req),
      .ready        (ready),
      .lookup_valid (lookup_valid),
      .lookup_index (lookup_index),
      .way_valid    (way_valid),
      .victim_valid (victim_valid),
      .victim_way   (victim_way),
      .access_valid (access_valid),
      .access_index (access_index),
      .access_way   (access_way)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      flush_req    = 1'b0;
      lookup_valid = 1'b0;
      access_valid = 1'b0;
   endtask

   task automatic touch(input logic [5:0] idx, input logic [2:0] way);
      access_valid = 1'b1;
      access_index = idx;
      access_way   = way;
      step();
      quiet();
   endtask

   task automatic lookup(input string tag, input logic [5:0] idx, input logic [2:0] exp);
      lookup_valid = 1'b1;
      lookup_index = idx;
      step();
      quiet();
      check({tag, "_valid"}, 32'(victim_valid), 32'd1);
      check({tag, "_way"}, 32'(victim_way), 32'(exp));
   endtask

   int         cnt;
   logic [2:0] exp_partial;
   logic [2:0] exp_none;

   initial begin
      resetn       = 1'b0;
      way_valid    = 8'hFF;
      lookup_index = '0;
      access_index = '0;
      access_way   = '0;
      quiet();
      step();
      step();
      resetn = 1'b1;
      check("rst_ready", 32'(ready), 32'd1);
      check("rst_vvalid", 32'(victim_valid), 32'd0);
      check("rst_vway", 32'(victim_way), 32'd0);

      lookup("lk5_init", 6'd5, 3'd0);
      step();
      check("pulse_low", 32'(victim_valid), 32'd0);

      touch(6'd5, 3'd0);
      lookup("lk5_a0", 6'd5, 3'd4);
      touch(6'd5, 3'd4);
      lookup("lk5_a4", 6'd5, 3'd2);
      check("hold_way_prep", 32'(victim_way), 32'd2);
      step();
      check("hold_way", 32'(victim_way), 32'd2);

      // same-cycle access and lookup on one index
      access_valid = 1'b1; access_index = 6'd9; access_way = 3'd0;
      lookup("fwd9", 6'd9, 3'd4);
      access_valid = 1'b1; access_index = 6'd9; access_way = 3'd1;
      lookup("nofwd10", 6'd10, 3'd0);

      // back-to-back lookups
      lookup_valid = 1'b1; lookup_index = 6'd5;
      step();
      check("b2b0_valid", 32'(victim_valid), 32'd1);
      check("b2b0_way", 32'(victim_way), 32'd2);
      lookup_index = 6'd9;
      step();
      quiet();
      check("b2b1_valid", 32'(victim_valid), 32'd1);
      check("b2b1_way", 32'(victim_way), 32'd4);

      for (int w = 0; w < 8; w++) touch(6'd3, 3'(w));
      lookup("seq3", 6'd3, 3'd0);

      // flush with a colliding access that must be dropped
      flush_req = 1'b1; access_valid = 1'b1; access_index = 6'd20; access_way = 3'd0;
      step();
      quiet();
      cnt = 0;
      while (!ready && cnt < 200) begin
         cnt++;
         step();
      end
      check("flush_cycles", 32'(cnt), 32'd64);
      lookup("post_fl5", 6'd5, 3'd0);
      lookup("post_fl9", 6'd9, 3'd0);
      lookup("post_fl3", 6'd3, 3'd0);
      lookup("post_fl20", 6'd20, 3'd0);

      // invalid-first selection
`ifdef PLRU_INVALID_FIRST_EN
      exp_partial = 3'd3;
      exp_none    = 3'd0;
`else
      exp_partial = 3'd4;
      exp_none    = 3'd4;
`endif
      touch(6'd21, 3'd0);
      way_valid = 8'b1111_0111;
      lookup("inv_partial", 6'd21, exp_partial);
      way_valid = 8'h00;
      lookup("inv_none", 6'd21, exp_none);
      way_valid = 8'hFF;
      lookup("inv_full", 6'd21, 3'd4);

      // reset in the middle of a flush sweep
      touch(6'd50, 3'd0);
      lookup("pre_rst50", 6'd50, 3'd4);
      flush_req = 1'b1;
      step();
      quiet();
      for (int i = 0; i < 10; i++) step();
      check("mid_flush_busy", 32'(ready), 32'd0);
      resetn = 1'b0;
      step();
      resetn = 1'b1;
      check("mrst_ready", 32'(ready), 32'd1);
      check("mrst_vvalid", 32'(victim_valid), 32'd0);
      check("mrst_vway", 32'(victim_way), 32'd0);
      lookup("mrst50", 6'd50, 3'd0);
      lookup("mrst21", 6'd21, 3'd0);
      lookup("mrst63", 6'd63, 3'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
